// File: rtl/hazard_sched_if.sv
// Decode-side handshake between the pipeline and the stall/flush scheduler.
interface hazard_sched_if #(parameter int unsigned CNT_W = 16);
  logic             id_valid;
  logic [2:0]       id_rX;
  logic [2:0]       id_rY;
  logic             id_rX_used;
  logic             id_rY_used;
  logic [2:0]       id_rO;
  logic             id_rf_en;
  logic             ex_redirect;
  logic             mem_stall;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             hazard;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rX, id_rY, id_rX_used, id_rY_used, id_rO, id_rf_en,
           ex_redirect, mem_stall,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, hazard, stall_cnt
  );

  modport slave (
    input  id_valid, id_rX, id_rY, id_rX_used, id_rY_used, id_rO, id_rf_en,
           ex_redirect, mem_stall,
    output pc_en, ifid_en, ifid_flush, idex_bubble, hazard, stall_cnt
  );
endinterface

// File: rtl/hazard_sched.sv
// Stall/flush scheduler for a 5-stage pipeline without forwarding: tracks in-flight
// destination registers, stalls decode on RAW hazards and counts stall cycles.
module hazard_sched #(
  parameter int unsigned DEPTH     = 3,
  parameter bit          WB_BYPASS = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input logic           clk,
  input logic           rst,
  hazard_sched_if.slave bus
);

  // With write-through the oldest slot is already visible to decode.
  localparam int unsigned CHK = WB_BYPASS ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] w;
  logic [2:0]       r [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic hit;
  logic hazard_c;
  logic issue_c;
  logic pc_en_c;
  logic ifid_en_c;
  logic ifid_flush_c;
  logic idex_bubble_c;

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < CHK; i++) begin
      if (v[i] && w[i] &&
          ((bus.id_rX_used && (r[i] == bus.id_rX)) ||
           (bus.id_rY_used && (r[i] == bus.id_rY))))
        hit = 1'b1;
    end
    hazard_c = bus.id_valid && hit;
  end

  // Pipeline enables: memory stall freezes everything, redirect flushes, hazard stalls.
  always_comb begin
    pc_en_c       = 1'b1;
    ifid_en_c     = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    if (bus.mem_stall) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
    end else if (bus.ex_redirect) begin
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (hazard_c) begin
      pc_en_c       = 1'b0;
      ifid_en_c     = 1'b0;
      idex_bubble_c = 1'b1;
    end
  end

  assign issue_c = bus.id_valid && !hazard_c && !bus.ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      w   <= '0;
      cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r[i] <= 3'd0;
    end else if (!bus.mem_stall) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        w[i] <= w[i-1];
        r[i] <= r[i-1];
      end
      v[0] <= issue_c;
      w[0] <= issue_c && bus.id_rf_en;
      r[0] <= issue_c ? bus.id_rO : 3'd0;
      if (!bus.ex_redirect && hazard_c && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.hazard      = hazard_c;
  assign bus.pc_en       = pc_en_c;
  assign bus.ifid_en     = ifid_en_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.stall_cnt   = cnt;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench: three scheduler instances (baseline, write-through, 2-bit counter) on shared stimulus.
module tb_hazard_sched;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_sched_if #(.CNT_W(16)) b0 ();
  hazard_sched_if #(.CNT_W(16)) b1 ();
  hazard_sched_if #(.CNT_W(2))  b2 ();

  hazard_sched #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  hazard_sched #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
  hazard_sched #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(2))  u2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one decode-stage input vector to all three instances and let it settle.
  task automatic drive(input logic vld, input logic [2:0] rx, input logic rxu,
                       input logic [2:0] ry, input logic ryu, input logic [2:0] ro,
                       input logic rfen, input logic redir, input logic ms);
    b0.id_valid = vld; b0.id_rX = rx; b0.id_rX_used = rxu; b0.id_rY = ry; b0.id_rY_used = ryu;
    b0.id_rO = ro; b0.id_rf_en = rfen; b0.ex_redirect = redir; b0.mem_stall = ms;
    b1.id_valid = vld; b1.id_rX = rx; b1.id_rX_used = rxu; b1.id_rY = ry; b1.id_rY_used = ryu;
    b1.id_rO = ro; b1.id_rf_en = rfen; b1.ex_redirect = redir; b1.mem_stall = ms;
    b2.id_valid = vld; b2.id_rX = rx; b2.id_rX_used = rxu; b2.id_rY = ry; b2.id_rY_used = ryu;
    b2.id_rO = ro; b2.id_rf_en = rfen; b2.ex_redirect = redir; b2.mem_stall = ms;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      idle();
      checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard cyc=%0d got=%b exp=0", k, b0.hazard); end
      checks++; if (b0.pc_en !== 1'b1) begin failures++; $display("FAIL reset_pc_en cyc=%0d got=%b exp=1", k, b0.pc_en); end
      checks++; if (b0.ifid_en !== 1'b1) begin failures++; $display("FAIL reset_ifid_en cyc=%0d got=%b exp=1", k, b0.ifid_en); end
      checks++; if (b0.ifid_flush !== 1'b0) begin failures++; $display("FAIL reset_flush cyc=%0d got=%b exp=0", k, b0.ifid_flush); end
      checks++; if (b0.idex_bubble !== 1'b0) begin failures++; $display("FAIL reset_bubble cyc=%0d got=%b exp=0", k, b0.idex_bubble); end
      checks++; if (b0.stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt cyc=%0d got=%0d exp=0", k, b0.stall_cnt); end
      tick();
    end
  endtask

  task automatic test_raw_stall();
    logic e0;
    logic e1;
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL raw_i1_hazard got=%b exp=0", b0.hazard); end
    tick();
    // I2 reads r1: baseline stalls 3 cycles, write-through stalls 2.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      e0 = (k < 3);
      e1 = (k < 2);
      checks++; if (b0.hazard !== e0) begin failures++; $display("FAIL raw_hazard k=%0d got=%b exp=%b", k, b0.hazard, e0); end
      checks++; if (b0.idex_bubble !== e0) begin failures++; $display("FAIL raw_bubble k=%0d got=%b exp=%b", k, b0.idex_bubble, e0); end
      checks++; if (b0.pc_en !== !e0) begin failures++; $display("FAIL raw_pc_en k=%0d got=%b exp=%b", k, b0.pc_en, !e0); end
      checks++; if (b1.hazard !== e1) begin failures++; $display("FAIL byp_hazard k=%0d got=%b exp=%b", k, b1.hazard, e1); end
      tick();
    end
    idle();
    checks++; if (b0.stall_cnt !== 16'd3) begin failures++; $display("FAIL raw_cnt got=%0d exp=3", b0.stall_cnt); end
    checks++; if (b1.stall_cnt !== 16'd2) begin failures++; $display("FAIL byp_cnt got=%0d exp=2", b1.stall_cnt); end
    checks++; if (b2.stall_cnt !== 2'd3) begin failures++; $display("FAIL raw_cnt2 got=%0d exp=3", b2.stall_cnt); end
  endtask

  task automatic test_no_write();
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL nowrite_hazard got=%b exp=0", b0.hazard); end
    checks++; if (b0.pc_en !== 1'b1) begin failures++; $display("FAIL nowrite_pc_en got=%b exp=1", b0.pc_en); end
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 1'b1, 3'd3, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL unused_ry_hazard got=%b exp=0", b0.hazard); end
    tick();
    // Same read with rY marked used must now hit the r3 writer one slot further on.
    drive(1'b1, 3'd5, 1'b1, 3'd3, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b1) begin failures++; $display("FAIL used_ry_hazard got=%b exp=1", b0.hazard); end
    drive(1'b0, 3'd5, 1'b1, 3'd3, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL invalid_hazard got=%b exp=0", b0.hazard); end
    checks++; if (b0.stall_cnt !== 16'd0) begin failures++; $display("FAIL nowrite_cnt got=%0d exp=0", b0.stall_cnt); end
    tick();
  endtask

  task automatic test_mem_stall();
    logic e;
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b1) begin failures++; $display("FAIL ms_pre_hazard got=%b exp=1", b0.hazard); end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
      checks++; if (b0.pc_en !== 1'b0) begin failures++; $display("FAIL ms_pc_en k=%0d got=%b exp=0", k, b0.pc_en); end
      checks++; if (b0.ifid_en !== 1'b0) begin failures++; $display("FAIL ms_ifid_en k=%0d got=%b exp=0", k, b0.ifid_en); end
      checks++; if (b0.idex_bubble !== 1'b0) begin failures++; $display("FAIL ms_bubble k=%0d got=%b exp=0", k, b0.idex_bubble); end
      checks++; if (b0.ifid_flush !== 1'b0) begin failures++; $display("FAIL ms_flush k=%0d got=%b exp=0", k, b0.ifid_flush); end
      checks++; if (b0.hazard !== 1'b1) begin failures++; $display("FAIL ms_hazard k=%0d got=%b exp=1", k, b0.hazard); end
      checks++; if (b0.stall_cnt !== 16'd1) begin failures++; $display("FAIL ms_cnt k=%0d got=%0d exp=1", k, b0.stall_cnt); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
      e = (k < 2);
      checks++; if (b0.hazard !== e) begin failures++; $display("FAIL ms_resume k=%0d got=%b exp=%b", k, b0.hazard, e); end
      tick();
    end
    idle();
    checks++; if (b0.stall_cnt !== 16'd3) begin failures++; $display("FAIL ms_total_cnt got=%0d exp=3", b0.stall_cnt); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
    checks++; if (b0.hazard !== 1'b1) begin failures++; $display("FAIL rd_hazard got=%b exp=1", b0.hazard); end
    checks++; if (b0.ifid_flush !== 1'b1) begin failures++; $display("FAIL rd_flush got=%b exp=1", b0.ifid_flush); end
    checks++; if (b0.idex_bubble !== 1'b1) begin failures++; $display("FAIL rd_bubble got=%b exp=1", b0.idex_bubble); end
    checks++; if (b0.pc_en !== 1'b1) begin failures++; $display("FAIL rd_pc_en got=%b exp=1", b0.pc_en); end
    checks++; if (b0.ifid_en !== 1'b1) begin failures++; $display("FAIL rd_ifid_en got=%b exp=1", b0.ifid_en); end
    tick();
    drive(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (b0.hazard !== 1'b0) begin failures++; $display("FAIL rd_killed_hazard got=%b exp=0", b0.hazard); end
    checks++; if (b0.stall_cnt !== 16'd0) begin failures++; $display("FAIL rd_cnt got=%0d exp=0", b0.stall_cnt); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    // I2 reads and writes r1, so it stalls, issues, then stalls on its own copy.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    checks++; if (b0.stall_cnt !== 16'd5) begin failures++; $display("FAIL sat_cnt16 got=%0d exp=5", b0.stall_cnt); end
    checks++; if (b2.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt2 got=%0d exp=3", b2.stall_cnt); end
    checks++; if (b2.hazard !== 1'b1) begin failures++; $display("FAIL sat_pending got=%b exp=1", b2.hazard); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    checks++; if (b2.hazard !== 1'b0) begin failures++; $display("FAIL rst_mid_hazard got=%b exp=0", b2.hazard); end
    checks++; if (b2.stall_cnt !== 2'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", b2.stall_cnt); end
    checks++; if (b0.pc_en !== 1'b1) begin failures++; $display("FAIL rst_mid_pc_en got=%b exp=1", b0.pc_en); end
    tick();
    idle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    test_reset();
    test_raw_stall();
    test_no_write();
    test_mem_stall();
    test_redirect();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
